// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA diagonal-window block: default pixel width,
// counter sizing helper and the frame FSM state encoding.
package cfa_pkg;

    localparam int unsigned CFA_PIX_W = 12;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } cfa_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// Write-enable-gated delay line: dout is the word written DEPTH enabled cycles ago.
// Circular buffer with an asynchronous read at the write pointer.
module cfa_line_buf
    import cfa_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned PW = cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;

    // The slot about to be overwritten holds the word from DEPTH writes ago.
    assign dout = mem[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (we) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    // NOTE: storage has no reset; stale contents are never presented as a valid window.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cfa_diag_window.sv
// Streaming 3x3 diagonal-neighbour generator for the green and R/B planes.
// Optional macro CFA_WIN_PHASE_EN adds win_phase = {row[0], col[0]} of the centre pixel.
module cfa_diag_window
    import cfa_pkg::*;
#(
    parameter int unsigned PIX_W = CFA_PIX_W,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] g_in,
    input  logic [PIX_W-1:0] rb_in,
    output logic             out_valid,
    output logic             out_eof,
    output logic             err_sof,
    output logic [PIX_W-1:0] G_m1_m1,
    output logic [PIX_W-1:0] G_m1_p1,
    output logic [PIX_W-1:0] G_p1_m1,
    output logic [PIX_W-1:0] G_p1_p1,
    output logic [PIX_W-1:0] RB_m1_m1,
    output logic [PIX_W-1:0] RB_m1_p1,
    output logic [PIX_W-1:0] RB_p1_m1,
    output logic [PIX_W-1:0] RB_p1_p1
`ifdef CFA_WIN_PHASE_EN
    ,
    output logic [1:0]       win_phase
`endif
);

    localparam int unsigned CW  = cnt_w(IMG_W);
    localparam int unsigned RW  = cnt_w(IMG_H);
    localparam int unsigned PW2 = 2 * PIX_W;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [PW2-1:0] pair_t;   // {green, r/b}

    cfa_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Window columns c-1 and c-2 for row r (cur) and row r-2 (top); the centre
    // row is never presented, so it is not stored.
    pair_t cur_m1_q, cur_m1_d, cur_m2_q, cur_m2_d;
    pair_t top_m1_q, top_m1_d, top_m2_q, top_m2_d;

    pair_t o_mm_q, o_mm_d, o_mp_q, o_mp_d, o_pm_q, o_pm_d, o_pp_q, o_pp_d;
    logic  out_valid_q, out_valid_d;
    logic  out_eof_q, out_eof_d;
    logic  err_sof_q, err_sof_d;
`ifdef CFA_WIN_PHASE_EN
    logic [1:0] phase_q, phase_d;
`endif

    logic          accept;
    logic [CW-1:0] pos_c;
    logic [RW-1:0] pos_r;
    logic          is_last;
    logic          emit;
    pair_t         pix_in;
    pair_t         tap1;      // row r-1, current column
    pair_t         tap2;      // row r-2, current column

    assign pix_in  = {g_in, rb_in};
    assign accept  = in_valid && (in_sof || (state_q == ST_ACTIVE));
    // An in_sof beat is always (0,0), whether it starts or aborts a frame.
    assign pos_c   = in_sof ? '0 : col_q;
    assign pos_r   = in_sof ? '0 : row_q;
    assign is_last = (pos_c == COL_LAST) && (pos_r == ROW_LAST);
    assign emit    = accept && (pos_c >= CW'(2)) && (pos_r >= RW'(2));

    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PW2)) u_buf1 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept),
        .din  (pix_in),
        .dout (tap1)
    );

    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PW2)) u_buf2 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept),
        .din  (tap1),
        .dout (tap2)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cur_m1_d    = cur_m1_q;
        cur_m2_d    = cur_m2_q;
        top_m1_d    = top_m1_q;
        top_m2_d    = top_m2_q;
        o_mm_d      = o_mm_q;
        o_mp_d      = o_mp_q;
        o_pm_d      = o_pm_q;
        o_pp_d      = o_pp_q;
        out_valid_d = emit;
        out_eof_d   = emit && is_last;
        err_sof_d   = accept && in_sof && (state_q == ST_ACTIVE);
`ifdef CFA_WIN_PHASE_EN
        phase_d     = phase_q;
`endif

        if (accept) begin
            cur_m1_d = pix_in;
            cur_m2_d = cur_m1_q;
            top_m1_d = tap2;
            top_m2_d = top_m1_q;

            if (is_last) begin
                state_d = ST_IDLE;
                col_d   = '0;
                row_d   = '0;
            end else begin
                state_d = ST_ACTIVE;
                if (pos_c == COL_LAST) begin
                    col_d = '0;
                    row_d = pos_r + RW'(1);
                end else begin
                    col_d = pos_c + CW'(1);
                    row_d = pos_r;
                end
            end
        end

        if (emit) begin
            o_mm_d = top_m2_q;
            o_mp_d = tap2;
            o_pm_d = cur_m2_q;
            o_pp_d = pix_in;
`ifdef CFA_WIN_PHASE_EN
            // Centre is (r-1, c-1): its parities are the inverted parities of (r, c).
            phase_d = {~pos_r[0], ~pos_c[0]};
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cur_m1_q    <= '0;
            cur_m2_q    <= '0;
            top_m1_q    <= '0;
            top_m2_q    <= '0;
            o_mm_q      <= '0;
            o_mp_q      <= '0;
            o_pm_q      <= '0;
            o_pp_q      <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            err_sof_q   <= 1'b0;
`ifdef CFA_WIN_PHASE_EN
            phase_q     <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cur_m1_q    <= cur_m1_d;
            cur_m2_q    <= cur_m2_d;
            top_m1_q    <= top_m1_d;
            top_m2_q    <= top_m2_d;
            o_mm_q      <= o_mm_d;
            o_mp_q      <= o_mp_d;
            o_pm_q      <= o_pm_d;
            o_pp_q      <= o_pp_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            err_sof_q   <= err_sof_d;
`ifdef CFA_WIN_PHASE_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign err_sof   = err_sof_q;
    assign G_m1_m1   = o_mm_q[PW2-1:PIX_W];
    assign G_m1_p1   = o_mp_q[PW2-1:PIX_W];
    assign G_p1_m1   = o_pm_q[PW2-1:PIX_W];
    assign G_p1_p1   = o_pp_q[PW2-1:PIX_W];
    assign RB_m1_m1  = o_mm_q[PIX_W-1:0];
    assign RB_m1_p1  = o_mp_q[PIX_W-1:0];
    assign RB_p1_m1  = o_pm_q[PIX_W-1:0];
    assign RB_p1_p1  = o_pp_q[PIX_W-1:0];
`ifdef CFA_WIN_PHASE_EN
    assign win_phase = phase_q;
`endif

endmodule

// File: tb/tb_cfa_diag_window.sv
// Self-checking bench for cfa_diag_window: frame-level reference model driven
// by directed scenarios with randomised in_valid duty and pixel data.
module tb_cfa_diag_window;

    localparam int PIX_W = 12;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [PIX_W-1:0] g_in = '0;
    logic [PIX_W-1:0] rb_in = '0;
    logic             out_valid, out_eof, err_sof;
    logic [PIX_W-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
    logic [PIX_W-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
`ifdef CFA_WIN_PHASE_EN
    logic [1:0]       win_phase;
`endif

    cfa_diag_window #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .g_in      (g_in),
        .rb_in     (rb_in),
        .out_valid (out_valid),
        .out_eof   (out_eof),
        .err_sof   (err_sof),
        .G_m1_m1   (G_m1_m1),
        .G_m1_p1   (G_m1_p1),
        .G_p1_m1   (G_p1_m1),
        .G_p1_p1   (G_p1_p1),
        .RB_m1_m1  (RB_m1_m1),
        .RB_m1_p1  (RB_m1_p1),
        .RB_p1_m1  (RB_p1_m1),
        .RB_p1_p1  (RB_p1_p1)
`ifdef CFA_WIN_PHASE_EN
        ,
        .win_phase (win_phase)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame membership, linear beat index, pixels of the current frame.
    bit               m_frame = 1'b0;
    int               m_k = 0;
    logic [PIX_W-1:0] pg  [IMG_H][IMG_W];
    logic [PIX_W-1:0] prb [IMG_H][IMG_W];

    logic             e_valid = 1'b0, e_eof = 1'b0, e_err = 1'b0;
    logic [PIX_W-1:0] e_g  [4] = '{default: '0};
    logic [PIX_W-1:0] e_rb [4] = '{default: '0};
    logic [1:0]       e_phase = 2'b00;

    int               n_win = 0, n_eof = 0, n_err = 0;
    logic [PIX_W-1:0] first_win [8];
    logic [PIX_W-1:0] eof_g_pp = '0;
    logic [1:0]       ph_log [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_win = 0;
        n_eof = 0;
        n_err = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input logic r_st, input logic v, input logic s,
                        input logic [PIX_W-1:0] g, input logic [PIX_W-1:0] rb);
        int r, c;
        bit acc;
        rst = r_st; in_valid = v; in_sof = s; g_in = g; rb_in = rb;
        if (r_st) begin
            m_frame = 1'b0;
            e_valid = 1'b0; e_eof = 1'b0; e_err = 1'b0; e_phase = 2'b00;
            for (int i = 0; i < 4; i++) begin
                e_g[i] = '0;
                e_rb[i] = '0;
            end
        end else begin
            acc     = v && (s || m_frame);
            e_err   = acc && s && m_frame;
            e_valid = 1'b0;
            e_eof   = 1'b0;
            if (acc) begin
                if (s) begin
                    m_k = 0;
                    m_frame = 1'b1;
                end
                r = m_k / IMG_W;
                c = m_k % IMG_W;
                pg[r][c]  = g;
                prb[r][c] = rb;
                if (r >= 2 && c >= 2) begin
                    e_valid = 1'b1;
                    e_eof   = (m_k == NPIX - 1);
                    e_g[0] = pg[r-2][c-2];  e_rb[0] = prb[r-2][c-2];
                    e_g[1] = pg[r-2][c];    e_rb[1] = prb[r-2][c];
                    e_g[2] = pg[r][c-2];    e_rb[2] = prb[r][c-2];
                    e_g[3] = pg[r][c];      e_rb[3] = prb[r][c];
                    e_phase = {((r - 1) % 2) == 1, ((c - 1) % 2) == 1};
                end
                m_k++;
                if (m_k == NPIX) m_frame = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, e_valid);
        check("out_eof",   out_eof,   e_eof);
        check("err_sof",   err_sof,   e_err);
        check("G_m1_m1",  G_m1_m1,  e_g[0]);
        check("G_m1_p1",  G_m1_p1,  e_g[1]);
        check("G_p1_m1",  G_p1_m1,  e_g[2]);
        check("G_p1_p1",  G_p1_p1,  e_g[3]);
        check("RB_m1_m1", RB_m1_m1, e_rb[0]);
        check("RB_m1_p1", RB_m1_p1, e_rb[1]);
        check("RB_p1_m1", RB_p1_m1, e_rb[2]);
        check("RB_p1_p1", RB_p1_p1, e_rb[3]);
`ifdef CFA_WIN_PHASE_EN
        check("win_phase", win_phase, e_phase);
`endif
        if (out_valid === 1'b1) begin
            if (n_win == 0) begin
                first_win[0] = G_m1_m1;  first_win[1] = G_m1_p1;
                first_win[2] = G_p1_m1;  first_win[3] = G_p1_p1;
                first_win[4] = RB_m1_m1; first_win[5] = RB_m1_p1;
                first_win[6] = RB_p1_m1; first_win[7] = RB_p1_p1;
            end
`ifdef CFA_WIN_PHASE_EN
            if (n_win < 2) ph_log[n_win] = win_phase;
`endif
            n_win++;
        end
        if (out_eof === 1'b1) begin
            n_eof++;
            eof_g_pp = G_p1_p1;
        end
        if (err_sof === 1'b1) n_err++;
    endtask

    // Sends the first n beats of a frame; idle gaps appear with probability (100-duty)%.
    task automatic send_partial(input int n, input int duty, input bit rnd);
        int r, c;
        logic [PIX_W-1:0] g, rb;
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) >= duty)
                step(1'b0, 1'b0, 1'b0, PIX_W'($urandom), PIX_W'($urandom));
            r = k / IMG_W;
            c = k % IMG_W;
            g  = rnd ? PIX_W'($urandom) : PIX_W'(r * 16 + c);
            rb = rnd ? PIX_W'($urandom) : PIX_W'(256 + r * 16 + c);
            step(1'b0, 1'b1, k == 0, g, rb);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, PIX_W'($urandom), PIX_W'($urandom));
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 12'h5a5, 12'ha5a);
        idle(2);

        // Full frame, continuous in_valid, formula pixels
        clear_counts();
        send_partial(NPIX, 100, 1'b0);
        idle(2);
        check("s1_windows", n_win, NWIN);
        check("s1_eof_count", n_eof, 1);
        check("s1_first_G_mm", first_win[0], 0);
        check("s1_first_G_mp", first_win[1], 2);
        check("s1_first_G_pm", first_win[2], 32);
        check("s1_first_G_pp", first_win[3], 34);
        check("s1_first_RB_mm", first_win[4], 256);
        check("s1_first_RB_mp", first_win[5], 258);
        check("s1_first_RB_pm", first_win[6], 288);
        check("s1_first_RB_pp", first_win[7], 290);
        check("s1_eof_G_pp", eof_g_pp, 87);
`ifdef CFA_WIN_PHASE_EN
        check("s1_phase0", ph_log[0], 2'b11);
        check("s1_phase1", ph_log[1], 2'b10);
`endif

        // Same frame with ~50% in_valid duty
        clear_counts();
        send_partial(NPIX, 50, 1'b0);
        idle(3);
        check("s2_windows", n_win, NWIN);
        check("s2_eof_count", n_eof, 1);
        check("s2_first_G_pp", first_win[3], 34);

        // Beats without in_sof before the frame are dropped
        clear_counts();
        junk(5);
        send_partial(NPIX, 100, 1'b0);
        idle(2);
        check("s3_windows", n_win, NWIN);
        check("s3_eof_count", n_eof, 1);
        check("s3_first_G_mm", first_win[0], 0);

        // in_sof at (3,4) aborts the frame
        send_partial(3 * IMG_W + 4, 100, 1'b1);
        clear_counts();
        send_partial(NPIX, 100, 1'b0);
        idle(2);
        check("s4_err_count", n_err, 1);
        check("s4_windows", n_win, NWIN);
        check("s4_eof_count", n_eof, 1);
        check("s4_first_G_mm", first_win[0], 0);

        // Reset pulse at (4,1), ignored junk, then a fresh random frame
        send_partial(4 * IMG_W + 1, 100, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'd65, 12'd321);
        junk(4);
        clear_counts();
        send_partial(NPIX, 50, 1'b1);
        idle(2);
        check("s5_windows", n_win, NWIN);
        check("s5_eof_count", n_eof, 1);
        check("s5_err_count", n_err, 0);

        // Back-to-back random frames
        clear_counts();
        send_partial(NPIX, 100, 1'b1);
        send_partial(NPIX, 100, 1'b1);
        idle(2);
        check("s6_windows", n_win, 2 * NWIN);
        check("s6_eof_count", n_eof, 2);
        check("s6_err_count", n_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
